alu_pipe: RTL and testbench

Parametrised, registered ALU for the pipelined MIPS datapath. It keeps the existing single-cycle function encoding: shifter, set-less-than, add/sub and logic unit selected by `final_func`. It adds a registered output stage with valid/ready handshakes and an iterative shift-add multiplier that produces a double-width result. It sits in the EX stage between the ID/EX register and the EX/MEM register, and the hazard unit stalls on `in_ready`.

---
 rtl/alu_pipe.sv | 208 ++++++++++++++++++++
 tb/tb_alu_pipe.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Registered EX-stage ALU: shifter / slt / add-sub / logic in one cycle, plus an
// iterative shift-add multiplier, behind a one-entry valid/ready output slot.
module alu_pipe #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic [SHAMT_W-1:0] const_amt,
  input  logic               amt_sel,
  input  logic [1:0]         shift_func,
  input  logic [1:0]         logic_func,
  input  logic               add_sub,
  input  logic [1:0]         final_func,
  input  logic               mul_en,
  input  logic               mul_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out,
  output logic [WIDTH-1:0]   out_hi,
  output logic               zero_flag,
  output logic               ovf_flag,
  output logic               busy
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; the producer holds its fields stable while valid is high and ready is low.

  localparam int CNT_W = SHAMT_W + 1;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic                 neg_q, neg_d;
  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     out_q, out_d;
  logic [WIDTH-1:0]     out_hi_q, out_hi_d;
  logic                 zero_q, zero_d;
  logic                 ovf_q, ovf_d;

  logic                 accept;
  logic                 slot_free;
  logic                 mul_done;
  logic                 mul_load;
  logic [SHAMT_W-1:0]   amt;
  logic [WIDTH-1:0]     shift_res;
  logic [WIDTH-1:0]     y_eff;
  logic [WIDTH-1:0]     low_sum;
  logic                 c_msb_in;
  logic                 c_msb_out;
  logic                 sum_msb;
  logic                 add_ovf;
  logic [WIDTH-1:0]     sum;
  logic [WIDTH-1:0]     slt_res;
  logic [WIDTH-1:0]     logic_res;
  logic [WIDTH-1:0]     alu_res;
  logic [WIDTH-1:0]     x_mag;
  logic [WIDTH-1:0]     y_mag;
  logic [2*WIDTH-1:0]   product;

  assign slot_free = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign mul_done  = (state_q == S_MUL) && (cnt_q == CNT_W'(WIDTH));
  assign mul_load  = mul_done && slot_free;

  // State register and all datapath flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      neg_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      out_hi_q    <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      neg_q       <= neg_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      out_hi_q    <= out_hi_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && mul_en) state_d = S_MUL;
      S_MUL:   if (mul_load) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy     = (state_q == S_MUL);
    in_ready = (state_q == S_IDLE) && slot_free && !reset;
  end

  // Single-cycle functional units.
  always_comb begin
    amt = amt_sel ? x[SHAMT_W-1:0] : const_amt;
    case (shift_func)
      2'b00:   shift_res = y;
      2'b01:   shift_res = y << amt;
      2'b10:   shift_res = y >> amt;
      default: shift_res = $unsigned($signed(y) >>> amt);
    endcase

    y_eff     = y ^ {WIDTH{add_sub}};
    low_sum   = {1'b0, x[WIDTH-2:0]} + {1'b0, y_eff[WIDTH-2:0]} + WIDTH'(add_sub);
    c_msb_in  = low_sum[WIDTH-1];
    sum_msb   = x[WIDTH-1] ^ y_eff[WIDTH-1] ^ c_msb_in;
    c_msb_out = (x[WIDTH-1] & y_eff[WIDTH-1]) | (x[WIDTH-1] & c_msb_in)
              | (y_eff[WIDTH-1] & c_msb_in);
    add_ovf   = c_msb_in ^ c_msb_out;
    sum       = {sum_msb, low_sum[WIDTH-2:0]};
    // True signed compare: the sign of the un-truncated difference.
    slt_res   = {{(WIDTH-1){1'b0}}, sum_msb ^ add_ovf};

    case (logic_func)
      2'b00:   logic_res = x & y;
      2'b01:   logic_res = x | y;
      2'b10:   logic_res = x ^ y;
      default: logic_res = ~(x | y);
    endcase

    case (final_func)
      2'b00:   alu_res = shift_res;
      2'b01:   alu_res = slt_res;
      2'b10:   alu_res = sum;
      default: alu_res = logic_res;
    endcase
  end

  // Multiplier iteration and output slot.
  always_comb begin
    x_mag    = (mul_signed && x[WIDTH-1]) ? -x : x;
    y_mag    = (mul_signed && y[WIDTH-1]) ? -y : y;
    product  = neg_q ? -acc_q : acc_q;

    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;

    if (state_q == S_IDLE && accept && mul_en) begin
      cnt_d    = '0;
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, x_mag};
      mplier_d = y_mag;
      neg_d    = mul_signed && (x[WIDTH-1] ^ y[WIDTH-1]);
    end else if (state_q == S_MUL && !mul_done) begin
      acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
    end

    out_valid_d = out_valid_q && !out_ready;
    out_d       = out_q;
    out_hi_d    = out_hi_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;

    // in_ready is low while MUL, so a new accept and a multiply load never coincide.
    if (accept && !mul_en) begin
      out_valid_d = 1'b1;
      out_d       = alu_res;
      out_hi_d    = '0;
      zero_d      = (alu_res == '0);
      ovf_d       = add_ovf;
    end else if (mul_load) begin
      out_valid_d = 1'b1;
      out_d       = product[WIDTH-1:0];
      out_hi_d    = product[2*WIDTH-1:WIDTH];
      zero_d      = (product[WIDTH-1:0] == '0);
      ovf_d       = 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign out_hi    = out_hi_q;
  assign zero_flag = zero_q;
  assign ovf_flag  = ovf_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed cases from the ALU behaviour plus randomized traffic
// with random backpressure, scored against an arithmetic reference model.
module tb_alu_pipe;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [4:0]  const_amt;
    logic        amt_sel;
    logic [1:0]  shift_func;
    logic [1:0]  logic_func;
    logic        add_sub;
    logic [1:0]  final_func;
    logic        mul_en;
    logic        mul_signed;
  } op_t;

  typedef struct packed {
    logic [31:0] out;
    logic [31:0] out_hi;
    logic        zero;
    logic        ovf;
  } res_t;

  localparam int RES_W = $bits(res_t);
  localparam longint MAX_S = 64'sh7FFF_FFFF;
  localparam longint MIN_S = -MAX_S - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  op_t         op_r = '0;
  logic        in_ready, out_valid, zero_flag, ovf_flag, busy;
  logic [31:0] out, out_hi;

  alu_pipe #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .x(op_r.x), .y(op_r.y),
    .const_amt(op_r.const_amt), .amt_sel(op_r.amt_sel),
    .shift_func(op_r.shift_func), .logic_func(op_r.logic_func),
    .add_sub(op_r.add_sub), .final_func(op_r.final_func),
    .mul_en(op_r.mul_en), .mul_signed(op_r.mul_signed),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .out_hi(out_hi),
    .zero_flag(zero_flag), .ovf_flag(ovf_flag), .busy(busy)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // ---------------- reference model ----------------
  function automatic res_t model(input op_t op);
    res_t        r;
    longint      sx, sy, tru;
    logic [63:0] p;
    logic [31:0] res;
    logic [4:0]  amt;
    r = '0;
    sx = int'(op.x);
    sy = int'(op.y);
    if (op.mul_en) begin
      if (op.mul_signed) p = sx * sy;
      else p = {32'b0, op.x} * {32'b0, op.y};
      r.out = p[31:0];
      r.out_hi = p[63:32];
      r.ovf = 1'b0;
    end else begin
      tru = op.add_sub ? sx - sy : sx + sy;
      r.ovf = (tru > MAX_S) || (tru < MIN_S);
      amt = op.amt_sel ? op.x[4:0] : op.const_amt;
      case (op.final_func)
        2'd0: case (op.shift_func)
                2'd0: res = op.y;
                2'd1: res = op.y << amt;
                2'd2: res = op.y >> amt;
                default: res = int'(op.y) >>> amt;
              endcase
        2'd1: res = (tru < 0) ? 32'd1 : 32'd0;
        2'd2: res = tru[31:0];
        default: case (op.logic_func)
                   2'd0: res = op.x & op.y;
                   2'd1: res = op.x | op.y;
                   2'd2: res = op.x ^ op.y;
                   default: res = ~(op.x | op.y);
                 endcase
      endcase
      r.out = res;
      r.out_hi = '0;
    end
    r.zero = (r.out == '0);
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  logic [RES_W-1:0] exp_q[$];
  logic             hold_pend = 1'b0;
  logic [RES_W-1:0] hold_val;

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) check("hold_stable", {out, out_hi, zero_flag, ovf_flag}, hold_val);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("spurious_result", 1, 0);
        else check("result", {out, out_hi, zero_flag, ovf_flag}, exp_q.pop_front());
      end
      if (in_valid && in_ready) exp_q.push_back(model(op_r));
      hold_pend = out_valid && !out_ready;
      hold_val  = {out, out_hi, zero_flag, ovf_flag};
    end
  end

  // ---------------- drivers ----------------
  logic rand_ready = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send_op(input op_t op);
    int waited = 0;
    op_r = op;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 200) begin
        check("accept_timeout", 0, 1);
        break;
      end
      tick();
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat, output int busy_cyc, output int rdy_cyc);
    lat = 0;
    busy_cyc = 0;
    rdy_cyc = 0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (out_valid) begin
        lat = k;
        break;
      end
      if (busy) busy_cyc++;
      if (in_ready) rdy_cyc++;
    end
    if (lat == 0) check("result_timeout", 0, 1);
  endtask

  function automatic op_t mk_alu(input logic [31:0] x, input logic [31:0] y,
                                 input logic [1:0] ff, input logic add_sub,
                                 input logic [1:0] sf, input logic amt_sel,
                                 input logic [4:0] ca);
    op_t o = '0;
    o.x = x; o.y = y; o.final_func = ff; o.add_sub = add_sub;
    o.shift_func = sf; o.amt_sel = amt_sel; o.const_amt = ca;
    return o;
  endfunction

  function automatic op_t mk_mul(input logic [31:0] x, input logic [31:0] y, input logic sgn);
    op_t o = '0;
    o.x = x; o.y = y; o.mul_en = 1'b1; o.mul_signed = sgn;
    return o;
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'h7FFF_FFFF;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.x = pick_val();
    o.y = pick_val();
    o.const_amt  = 5'($urandom_range(0, 31));
    o.amt_sel    = 1'($urandom_range(0, 1));
    o.shift_func = 2'($urandom_range(0, 3));
    o.logic_func = 2'($urandom_range(0, 3));
    o.add_sub    = 1'($urandom_range(0, 1));
    o.final_func = 2'($urandom_range(0, 3));
    o.mul_en     = ($urandom_range(0, 7) == 0);
    o.mul_signed = 1'($urandom_range(0, 1));
    return o;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int lat, bcyc, rcyc, waited;

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out", out, 0);
    check("rst_out_hi", out_hi, 0);
    check("rst_zero", zero_flag, 0);
    check("rst_ovf", ovf_flag, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    reset = 1'b0;
    #1;
    check("ready_after_rst", in_ready, 1);

    // Add overflow, one-cycle latency.
    send_op(mk_alu(32'h7FFF_FFFF, 32'd1, 2'b10, 1'b0, 2'b00, 1'b0, 5'd0));
    check("add_latency", out_valid, 1);
    check("add_out", out, 32'h8000_0000);
    check("add_ovf", ovf_flag, 1);
    check("add_zero", zero_flag, 0);

    // Signed set-less-than.
    send_op(mk_alu(32'h8000_0000, 32'd1, 2'b01, 1'b1, 2'b00, 1'b0, 5'd0));
    check("slt_neg_out", out, 32'd1);
    send_op(mk_alu(32'd5, 32'd5, 2'b01, 1'b1, 2'b00, 1'b0, 5'd0));
    check("slt_eq_out", out, 32'd0);
    check("slt_eq_zero", zero_flag, 1);

    // Arithmetic shifts, immediate and register amounts.
    send_op(mk_alu(32'd0, 32'h8000_0000, 2'b00, 1'b0, 2'b11, 1'b0, 5'd4));
    check("sra_const", out, 32'hF800_0000);
    send_op(mk_alu(32'h21, 32'h8000_0000, 2'b00, 1'b0, 2'b11, 1'b1, 5'd4));
    check("sra_reg", out, 32'hC000_0000);

    // Signed multiply, latency and stall behaviour.
    send_op(mk_mul(32'hFFFF_FFFD, 32'd7, 1'b1));
    check("mul_busy_start", busy, 1);
    wait_result(lat, bcyc, rcyc);
    check("mul_latency", lat, 33);
    check("mul_busy_cycles", bcyc, 32);
    check("mul_in_ready_low", rcyc, 0);
    check("mul_busy_end", busy, 0);
    check("smul_hi", out_hi, 32'hFFFF_FFFF);
    check("smul_lo", out, 32'hFFFF_FFEB);
    check("smul_ovf", ovf_flag, 0);

    // Unsigned multiply.
    send_op(mk_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0));
    wait_result(lat, bcyc, rcyc);
    check("umul_hi", out_hi, 32'hFFFF_FFFE);
    check("umul_lo", out, 32'h0000_0001);
    tick();
    tick();

    // Backpressure: one result held, next two sources stall until release.
    out_ready = 1'b0;
    send_op(mk_alu(32'd10, 32'd20, 2'b10, 1'b0, 2'b00, 1'b0, 5'd0));
    check("bp_first_valid", out_valid, 1);
    fork
      begin
        send_op(mk_alu(32'd100, 32'd1, 2'b10, 1'b1, 2'b00, 1'b0, 5'd0));
        send_op(mk_alu(32'hF0, 32'h0F, 2'b11, 1'b0, 2'b00, 1'b0, 5'd0));
      end
      begin
        repeat (3) begin
          @(negedge clk);
          check("bp_in_ready", in_ready, 0);
          check("bp_out_stable", out, 32'd30);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    repeat (3) tick();
    check("bp_drained", exp_q.size(), 0);

    // Reset in the middle of a multiply aborts it.
    send_op(mk_mul(32'd1234, 32'd5678, 1'b0));
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_out_valid", out_valid, 0);
    rcyc = 0;
    repeat (40) begin
      tick();
      if (out_valid) rcyc++;
    end
    check("abort_no_result", rcyc, 0);

    // Randomized traffic with random backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send_op(rand_op());
      repeat ($urandom_range(0, 2)) tick();
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    waited = 0;
    while ((exp_q.size() != 0 || busy || out_valid) && waited < 100) begin
      tick();
      waited++;
    end
    check("final_drain", exp_q.size(), 0);
    check("final_idle", {busy, out_valid}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
